// File: rtl/hcp_pkg.sv
// Shared types and constants for the HCP transmit-side frame merger.
package hcp_pkg;

  localparam int unsigned BYTE_W            = 9;
  localparam int unsigned FLAG_BIT          = 8;
  localparam int unsigned DEF_MAX_FRAME_LEN = 1522;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    TRANS = 2'd2,
    GAP   = 2'd3
  } merge_state_e;

  // FIFO entry: payload byte plus end-of-frame marker
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } hcp_byte_t;

endpackage

// File: rtl/hcp_merge_ingress.sv
// Per-source ingress: write pipeline, frame admission/truncation, byte FIFO, frame counter.
// HCP_MERGE_STATS_EN adds a saturating drop counter and a truncation event pulse.
module hcp_merge_ingress
  import hcp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 2048,
  parameter int unsigned MAX_FRAME_LEN = DEF_MAX_FRAME_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data,
  input  logic              wr,
  input  logic              rd,
  input  logic              take,
  output hcp_byte_t         q,
  output logic              pending_c
`ifdef HCP_MERGE_STATS_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic              trunc_evt
`endif
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = $clog2(MAX_FRAME_LEN + 1);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

  hcp_byte_t      mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr, usedw;
  logic [LW-1:0]  len, idx;
  logic [FCW-1:0] frame_cnt;
  logic [7:0]     d_r;
  logic           wr_prev, active, start, admit, store, at_max;
  logic           st_r, max_r, last_w, commit;
  logic           unused_flag;

  assign unused_flag = data[FLAG_BIT];

  assign usedw     = wr_ptr - rd_ptr;
  assign start     = wr && !wr_prev;
  assign admit     = (FIFO_DEPTH - 32'(usedw)) >= MAX_FRAME_LEN;
  assign idx       = start ? '0 : len;
  assign store     = wr && (start ? admit : active);
  assign at_max    = (idx == LW'(MAX_FRAME_LEN - 1));
  assign last_w    = max_r || !wr;
  assign commit    = st_r && last_w;
  assign pending_c = (frame_cnt != '0);

  // Tracks wr through reset too, so a run already high at reset release has no start
  always_ff @(posedge clk) wr_prev <= wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      len    <= '0;
      st_r   <= 1'b0;
      max_r  <= 1'b0;
      d_r    <= '0;
    end else begin
      st_r   <= store;
      max_r  <= at_max;
      d_r    <= data[7:0];
      active <= store && !at_max;
      if (store) len <= LW'(idx + LW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (st_r) mem[wr_ptr[AW-1:0]] <= '{last: last_w, data: d_r};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q         <= '0;
      frame_cnt <= '0;
    end else begin
      if (st_r) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd) begin
        q      <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      frame_cnt <= frame_cnt + FCW'(commit) - FCW'(take);
    end
  end

`ifdef HCP_MERGE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt  <= '0;
      trunc_evt <= 1'b0;
    end else begin
      if (start && !admit && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      // Truncated only if the run is still going when the forced-last byte lands
      trunc_evt <= commit && max_r && wr;
    end
  end
`endif

endmodule

// File: rtl/hcp_frame_merge.sv
// Merges encapsulation and decapsulation frames into one 9-bit host stream with a fixed gap.
// HCP_MERGE_STATS_EN adds drop and truncation statistics outputs.
module hcp_frame_merge
  import hcp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 2048,
  parameter int unsigned MAX_FRAME_LEN = DEF_MAX_FRAME_LEN,
  parameter int unsigned IFG_CYCLES    = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] iv_enc_data,
  input  logic              i_enc_data_wr,
  input  logic [BYTE_W-1:0] iv_dec_data,
  input  logic              i_dec_data_wr,
  output logic [BYTE_W-1:0] ov_data,
  output logic              o_data_wr,
  output logic [1:0]        ov_merge_state
`ifdef HCP_MERGE_STATS_EN
  ,
  output logic [15:0]       ov_enc_drop_cnt,
  output logic [15:0]       ov_dec_drop_cnt,
  output logic [15:0]       ov_trunc_cnt
`endif
);

  localparam int unsigned GW = $clog2(IFG_CYCLES);

  merge_state_e      state, state_nx;
  logic              sel, sel_nx, rr, rr_nx;
  logic [GW-1:0]     gap, gap_nx;
  logic [BYTE_W-1:0] data_nx;
  logic              wr_nx;
  logic              rd_enc, rd_dec, take_enc, take_dec, pend_enc, pend_dec;
  hcp_byte_t         q_enc, q_dec, q_sel;

`ifdef HCP_MERGE_STATS_EN
  logic        trunc_enc, trunc_dec;
  logic [16:0] trunc_sum;
`endif

  hcp_merge_ingress #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_FRAME_LEN(MAX_FRAME_LEN)) u_enc (
    .clk(i_clk), .rst(i_rst), .data(iv_enc_data), .wr(i_enc_data_wr),
    .rd(rd_enc), .take(take_enc), .q(q_enc), .pending_c(pend_enc)
`ifdef HCP_MERGE_STATS_EN
    , .drop_cnt(ov_enc_drop_cnt), .trunc_evt(trunc_enc)
`endif
  );

  hcp_merge_ingress #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_FRAME_LEN(MAX_FRAME_LEN)) u_dec (
    .clk(i_clk), .rst(i_rst), .data(iv_dec_data), .wr(i_dec_data_wr),
    .rd(rd_dec), .take(take_dec), .q(q_dec), .pending_c(pend_dec)
`ifdef HCP_MERGE_STATS_EN
    , .drop_cnt(ov_dec_drop_cnt), .trunc_evt(trunc_dec)
`endif
  );

  assign q_sel          = sel ? q_dec : q_enc;
  assign ov_merge_state = 2'(state);

  // GAP lasts IFG_CYCLES-1 cycles; the IDLE decision cycle supplies the final idle beat
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    rr_nx    = rr;
    gap_nx   = gap;
    data_nx  = '0;
    wr_nx    = 1'b0;
    rd_enc   = 1'b0;
    rd_dec   = 1'b0;
    take_enc = 1'b0;
    take_dec = 1'b0;
    case (state)
      IDLE: begin
        if (pend_enc || pend_dec) begin
          sel_nx = (pend_enc && pend_dec) ? rr : !pend_enc;
          if (pend_enc && pend_dec) rr_nx = !rr;
          rd_enc   = !sel_nx;
          rd_dec   = sel_nx;
          take_enc = !sel_nx;
          take_dec = sel_nx;
          state_nx = FIRST;
        end
      end
      FIRST, TRANS: begin
        data_nx = {q_sel.last || (state == FIRST), q_sel.data};
        wr_nx   = 1'b1;
        rd_enc  = !sel && !q_sel.last;
        rd_dec  = sel && !q_sel.last;
        if (q_sel.last) begin
          state_nx = GAP;
          gap_nx   = GW'(IFG_CYCLES - 2);
        end else begin
          state_nx = TRANS;
        end
      end
      GAP: begin
        if (gap == '0) state_nx = IDLE;
        else gap_nx = gap - GW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      sel       <= 1'b0;
      rr        <= 1'b0;
      gap       <= '0;
      ov_data   <= '0;
      o_data_wr <= 1'b0;
    end else begin
      state     <= state_nx;
      sel       <= sel_nx;
      rr        <= rr_nx;
      gap       <= gap_nx;
      ov_data   <= data_nx;
      o_data_wr <= wr_nx;
    end
  end

`ifdef HCP_MERGE_STATS_EN
  assign trunc_sum = 17'(ov_trunc_cnt) + 17'(trunc_enc) + 17'(trunc_dec);

  always_ff @(posedge i_clk) begin
    if (i_rst) ov_trunc_cnt <= '0;
    else       ov_trunc_cnt <= trunc_sum[16] ? 16'hFFFF : trunc_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_hcp_frame_merge.sv
// Scoreboard bench for hcp_frame_merge: frame-level reference model, directed and random traffic.
module tb_hcp_frame_merge;

  localparam int unsigned FIFO_DEPTH = 2048;
  localparam int unsigned MAX_LEN    = 1522;
  localparam int unsigned IFG        = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] enc_d, dec_d, ov_data;
  logic       enc_wr, dec_wr, o_data_wr;
  logic [1:0] st;
`ifdef HCP_MERGE_STATS_EN
  logic [15:0] enc_drop, dec_drop, trunc;
`endif

  hcp_frame_merge #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_FRAME_LEN(MAX_LEN), .IFG_CYCLES(IFG)) dut (
    .i_clk(clk), .i_rst(rst),
    .iv_enc_data(enc_d), .i_enc_data_wr(enc_wr),
    .iv_dec_data(dec_d), .i_dec_data_wr(dec_wr),
    .ov_data(ov_data), .o_data_wr(o_data_wr), .ov_merge_state(st)
`ifdef HCP_MERGE_STATS_EN
    , .ov_enc_drop_cnt(enc_drop), .ov_dec_drop_cnt(dec_drop), .ov_trunc_cnt(trunc)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  // Expected bytes per source: {end_of_frame, bit8, data}
  logic [9:0] exp_enc[$], exp_dec[$];
  int log_src[$], log_start[$], log_end[$];
  int last_in_cyc[2];
  bit in_frame = 0, have_prev = 0;
  int cur_src, fstart, prev_end;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), need %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a byte
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst) begin
      in_frame  = 0;
      have_prev = 0;
    end else begin
      if (in_frame && !o_data_wr) begin
        n_vec++; n_err++;
        $display("FAIL bubble: o_data_wr=0 inside a frame at cycle %0d, need 1", cyc);
        in_frame = 0;
      end
      if (o_data_wr) begin
        if (!in_frame) begin
          cur_src  = int'(ov_data[7]);
          fstart   = cyc;
          in_frame = 1;
          if (have_prev) begin
            n_vec++;
            if (cyc - prev_end - 1 < int'(IFG)) begin
              n_err++;
              $display("FAIL ifg_min: gap %0d cycles at cycle %0d, need >= %0d", cyc - prev_end - 1, cyc, IFG);
            end
          end
        end
        if ((cur_src == 0 && exp_enc.size() == 0) || (cur_src == 1 && exp_dec.size() == 0)) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_byte: got 0x%03h at cycle %0d, need no output", ov_data, cyc);
          in_frame = 0;
        end else begin
          if (cur_src == 0) e = exp_enc.pop_front();
          else              e = exp_dec.pop_front();
          check("out_byte", int'(ov_data), int'(e[8:0]));
          if (e[9]) begin
            in_frame  = 0;
            have_prev = 1;
            prev_end  = cyc;
            log_src.push_back(cur_src);
            log_start.push_back(fstart);
            log_end.push_back(cyc);
          end
        end
      end
    end
  end

  // Drives one contiguous run; the model admits/truncates the frame at its first byte
  task automatic send(input int src, input int len, input bit rnd, input bit expect_it);
    logic [7:0] d[$];
    int n, used;
    n = (len > int'(MAX_LEN)) ? int'(MAX_LEN) : len;
    for (int i = 0; i < len; i++) d.push_back(rnd ? {src[0], 7'($urandom)} : {src[0], 7'(i)});
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      if (i == 0 && expect_it) begin
        used = (src == 0) ? exp_enc.size() : exp_dec.size();
        if (int'(FIFO_DEPTH) - used >= int'(MAX_LEN)) begin
          for (int j = 0; j < n; j++) begin
            logic [9:0] e;
            e = {j == n - 1, (j == 0 || j == n - 1), d[j]};
            if (src == 0) exp_enc.push_back(e);
            else          exp_dec.push_back(e);
          end
        end
      end
      if (src == 0) begin enc_d = {1'($urandom), d[i]}; enc_wr = 1'b1; end
      else          begin dec_d = {1'($urandom), d[i]}; dec_wr = 1'b1; end
      if (i == len - 1) last_in_cyc[src] = cyc;
    end
    @(posedge clk); #1;
    if (src == 0) enc_wr = 1'b0;
    else          dec_wr = 1'b0;
  endtask

  task automatic assert_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_enc.delete(); exp_dec.delete();
    log_src.delete(); log_start.delete(); log_end.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((exp_enc.size() != 0 || exp_dec.size() != 0 || in_frame) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL drain_timeout: %0d enc + %0d dec bytes outstanding after %0d cycles, need 0",
               exp_enc.size(), exp_dec.size(), budget);
    end
    repeat (IFG + 4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int len, nf;
    rst = 1'b1; enc_wr = 1'b0; dec_wr = 1'b0; enc_d = '0; dec_d = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_data", int'(ov_data), 0);
    check("rst_wr", int'(o_data_wr), 0);
    check("rst_state", int'(st), 0);

    // Single 64-byte enc frame: latency and length
    send(0, 64, 1'b0, 1'b1);
    wait_drain(400);
    check("t1_frames", log_src.size(), 1);
    if (log_src.size() >= 1) begin
      check("t1_latency", log_start[0], last_in_cyc[0] + 4);
      check("t1_len", log_end[0] - log_start[0] + 1, 64);
    end

    // Simultaneous commits: enc first, then exact gap
    assert_rst();
    fork
      send(0, 60, 1'b1, 1'b1);
      send(1, 60, 1'b1, 1'b1);
    join
    wait_drain(600);
    check("t2_frames", log_src.size(), 2);
    if (log_src.size() >= 2) begin
      check("t2_first_src", log_src[0], 0);
      check("t2_second_src", log_src[1], 1);
      check("t2_gap", log_start[1] - log_end[0] - 1, int'(IFG));
    end

    // Three back-to-back frames per source alternate with exact gaps
    assert_rst();
    fork
      repeat (3) send(0, 60, 1'b1, 1'b1);
      repeat (3) send(1, 60, 1'b1, 1'b1);
    join
    wait_drain(2000);
    check("t3_frames", log_src.size(), 6);
    for (int k = 0; k < log_src.size(); k++) begin
      check("t3_src", log_src[k], k % 2);
      if (k > 0) check("t3_gap", log_start[k] - log_end[k-1] - 1, int'(IFG));
    end

    // Over-long dec run truncated to MAX_LEN
    assert_rst();
    send(1, 1600, 1'b1, 1'b1);
    wait_drain(4000);
    check("t4_frames", log_src.size(), 1);
    if (log_src.size() >= 1) check("t4_len", log_end[0] - log_start[0] + 1, int'(MAX_LEN));
`ifdef HCP_MERGE_STATS_EN
    check("t4_trunc_cnt", int'(trunc), 1);
`endif

    // Admission: second enc frame arrives while the first is stalled behind dec
    assert_rst();
    fork
      send(1, 1522, 1'b1, 1'b1);
      begin
        repeat (10) @(posedge clk);
        send(0, 1522, 1'b1, 1'b1);
        send(0, 1522, 1'b1, 1'b1);
      end
    join
    wait_drain(4000);
    check("t5_frames", log_src.size(), 2);
    if (log_src.size() >= 2) begin
      check("t5_first_src", log_src[0], 1);
      check("t5_second_src", log_src[1], 0);
      check("t5_enc_len", log_end[1] - log_start[1] + 1, 1522);
    end
`ifdef HCP_MERGE_STATS_EN
    check("t5_enc_drop", int'(enc_drop), 1);
    check("t5_dec_drop", int'(dec_drop), 0);
`endif

    // Reset during output byte 20 while another enc run straddles the reset
    assert_rst();
    send(0, 64, 1'b1, 1'b1);
    fork
      send(0, 100, 1'b1, 1'b0);
      begin
        for (int k = 0; k < 50 && !o_data_wr; k++) @(negedge clk);
        check("t6_out_started", int'(o_data_wr), 1);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        exp_enc.delete(); exp_dec.delete();
        log_src.delete(); log_start.delete(); log_end.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t6_abort_wr", int'(o_data_wr), 0);
        check("t6_abort_data", int'(ov_data), 0);
      end
    join
    repeat (40) @(negedge clk);
    check("t6_quiet", log_src.size(), 0);
    send(0, 40, 1'b1, 1'b1);
    wait_drain(400);
    check("t6_frames", log_src.size(), 1);
    if (log_src.size() >= 1) check("t6_len", log_end[0] - log_start[0] + 1, 40);

    // Randomized bursts on both sources
    assert_rst();
    for (int it = 0; it < 20; it++) begin
      fork
        begin
          repeat ($urandom_range(0, 20)) @(posedge clk);
          nf = $urandom_range(0, 2);
          repeat (nf) begin
            len = ($urandom_range(0, 7) == 0) ? 1 : $urandom_range(2, 200);
            send(0, len, 1'b1, 1'b1);
            repeat ($urandom_range(0, 4)) @(posedge clk);
          end
        end
        begin
          int ld, nd;
          repeat ($urandom_range(0, 20)) @(posedge clk);
          nd = $urandom_range(0, 2);
          repeat (nd) begin
            ld = ($urandom_range(0, 7) == 0) ? 1 : $urandom_range(2, 200);
            send(1, ld, 1'b1, 1'b1);
            repeat ($urandom_range(0, 4)) @(posedge clk);
          end
        end
      join
      wait_drain(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
